// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding
// and default values for the loader parameters.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_e;

    localparam logic [63:0] DEF_BASE_ADDR = 64'd0;
    localparam logic [15:0] DEF_MAX_WORDS = 16'd1024;
    localparam logic [15:0] DEF_TIMEOUT   = 16'd1000;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs incoming bytes little-endian into a 32-bit word.
// Ports: clk_i, rst_ni, clr_i (drop partial word), shift_i (byte in),
//        byte_i, word_o (packed word), last_o (4th byte this cycle).
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    // New bytes enter at the top, so the first byte ends in [7:0].
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_i) begin
            word_d = {byte_i, word_q[31:8]};
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o = word_q;
    assign last_o = shift_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed byte program into instruction memory.
// Ports: CLK, RST (async low), START, BYTE_IN/BYTE_VALID/BYTE_READY,
//        WADDRESS/DATAIN/WR (memory write), CORE_RST, BUSY, DONE, ERR,
//        WORDS_WRITTEN.
module instr_loader
    import loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [15:0] MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic [63:0] WADDRESS,
    output logic [31:0] DATAIN,
    output logic        WR,
    output logic        CORE_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] WORDS_WRITTEN
);

    state_e      st_q, st_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] to_q, to_d;
    logic [15:0] n_len;
    logic [15:0] cnt_inc;
    logic        accept;
    logic        restart;
    logic        to_hit;
    logic        pk_last;
    logic [31:0] pk_word;

    assign BYTE_READY = (st_q == ST_LEN0) || (st_q == ST_LEN1)
                     || (st_q == ST_DATA);
    assign accept  = BYTE_VALID && BYTE_READY;
    assign restart = START && ((st_q == ST_IDLE) || (st_q == ST_DONE)
                     || (st_q == ST_ERROR));
    assign n_len   = {BYTE_IN, len_q[7:0]};
    assign cnt_inc = cnt_q + 16'd1;
    // 17-bit compare so a counter at 16'hFFFF cannot wrap past the limit.
    assign to_hit  = ({1'b0, to_q} + 17'd1) >= {1'b0, TIMEOUT};

    byte_packer u_packer (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .clr_i   (restart),
        .shift_i (accept && (st_q == ST_DATA)),
        .byte_i  (BYTE_IN),
        .word_o  (pk_word),
        .last_o  (pk_last)
    );

    always_comb begin
        st_d  = st_q;
        len_d = len_q;
        cnt_d = cnt_q;
        to_d  = '0;
        unique case (st_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (START) begin
                    st_d  = ST_LEN0;
                    cnt_d = '0;
                    len_d = '0;
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    len_d[7:0] = BYTE_IN;
                    st_d       = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    len_d = n_len;
                    if (n_len == 16'd0)
                        st_d = ST_DONE;
                    else if (n_len > MAX_WORDS)
                        st_d = ST_ERROR;
                    else
                        st_d = ST_DATA;
                end else if (to_hit) begin
                    st_d = ST_ERROR;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (pk_last)
                        st_d = ST_WRITE;
                end else if (to_hit) begin
                    st_d = ST_ERROR;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_inc;
                st_d  = (cnt_inc == len_q) ? ST_DONE : ST_DATA;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st_q  <= ST_IDLE;
            len_q <= '0;
            cnt_q <= '0;
            to_q  <= '0;
        end else begin
            st_q  <= st_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign WR       = (st_q == ST_WRITE);
    assign WADDRESS = WR ? (BASE_ADDR + {46'd0, cnt_q, 2'b00}) : 64'd0;
    assign DATAIN   = WR ? pk_word : 32'd0;
    assign CORE_RST = (st_q != ST_DONE);
    assign BUSY     = (st_q == ST_LEN0) || (st_q == ST_LEN1)
                   || (st_q == ST_DATA) || (st_q == ST_WRITE);
    assign DONE     = (st_q == ST_DONE);
    assign ERR      = (st_q == ST_ERROR);
    assign WORDS_WRITTEN = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: load, zero/oversize length,
// timeout, streaming valid and reset mid-load.
module tb_instr_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic [63:0] WADDRESS;
    logic [31:0] DATAIN;
    logic        WR;
    logic        CORE_RST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] WORDS_WRITTEN;

    int total = 0;
    int bad   = 0;

    logic [63:0] wa[$];
    logic [31:0] wd[$];
    logic        mon_rdy = 1'b0;
    int          rdy_viol = 0;

    instr_loader #(
        .BASE_ADDR (64'd0),
        .MAX_WORDS (16'd1024),
        .TIMEOUT   (16'd16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .START         (START),
        .BYTE_IN       (BYTE_IN),
        .BYTE_VALID    (BYTE_VALID),
        .BYTE_READY    (BYTE_READY),
        .WADDRESS      (WADDRESS),
        .DATAIN        (DATAIN),
        .WR            (WR),
        .CORE_RST      (CORE_RST),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERR           (ERR),
        .WORDS_WRITTEN (WORDS_WRITTEN)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WR) begin
            wa.push_back(WADDRESS);
            wd.push_back(DATAIN);
        end
        if (mon_rdy && BUSY && !BYTE_READY && !WR)
            rdy_viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    // Returns #1 after the edge on which the byte was taken.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        while (!BYTE_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50)
            chk("rdy_wait", 64'(n), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        RST        = 1'b0;
        START      = 1'b0;
        BYTE_IN    = 8'h00;
        BYTE_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_core", 64'(CORE_RST), 64'd1);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_rdy", 64'(BYTE_READY), 64'd0);
        chk("rst_wr", 64'(WR), 64'd0);
        chk("rst_cnt", 64'(WORDS_WRITTEN), 64'd0);
        chk("rst_flags", 64'({DONE, ERR}), 64'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_rdy", 64'(BYTE_READY), 64'd0);

        // Two-word load
        clr_log();
        start_pulse();
        chk("len0_busy", 64'(BUSY), 64'd1);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        BYTE_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        chk("ld2_nwr", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            chk("ld2_a0", wa[0], 64'h0);
            chk("ld2_d0", 64'(wd[0]), 64'h00000013);
            chk("ld2_a1", wa[1], 64'h4);
            chk("ld2_d1", 64'(wd[1]), 64'h00100093);
        end
        chk("ld2_done", 64'(DONE), 64'd1);
        chk("ld2_core", 64'(CORE_RST), 64'd0);
        chk("ld2_cnt", 64'(WORDS_WRITTEN), 64'd2);
        chk("done_rdy", 64'(BYTE_READY), 64'd0);

        // Zero length
        clr_log();
        start_pulse();
        chk("restart_cnt", 64'(WORDS_WRITTEN), 64'd0);
        send(8'h00); send(8'h00);
        BYTE_VALID = 1'b0;
        chk("zero_done", 64'(DONE), 64'd1);
        chk("zero_core", 64'(CORE_RST), 64'd0);
        @(negedge CLK);
        chk("zero_nwr", 64'(wa.size()), 64'd0);

        // Oversize length 1025
        clr_log();
        start_pulse();
        send(8'h01); send(8'h04);
        BYTE_VALID = 1'b0;
        @(negedge CLK);
        chk("big_err", 64'(ERR), 64'd1);
        chk("big_core", 64'(CORE_RST), 64'd1);
        chk("big_busy", 64'(BUSY), 64'd0);
        chk("big_nwr", 64'(wa.size()), 64'd0);

        // Timeout after one word of two
        clr_log();
        start_pulse();
        chk("err_clr", 64'(ERR), 64'd0);
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        BYTE_VALID = 1'b0;
        @(posedge CLK);
        repeat (15) @(posedge CLK);
        #1;
        chk("to_early", 64'(ERR), 64'd0);
        @(posedge CLK);
        #1;
        chk("to_err", 64'(ERR), 64'd1);
        chk("to_cnt", 64'(WORDS_WRITTEN), 64'd1);
        chk("to_nwr", 64'(wa.size()), 64'd1);

        // Continuous valid, three words
        clr_log();
        start_pulse();
        rdy_viol = 0;
        mon_rdy  = 1'b1;
        send(8'h03); send(8'h00);
        for (int i = 1; i <= 12; i++)
            send(8'(i));
        BYTE_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        mon_rdy = 1'b0;
        chk("str_viol", 64'(rdy_viol), 64'd0);
        chk("str_nwr", 64'(wa.size()), 64'd3);
        if (wa.size() == 3) begin
            chk("str_a0", wa[0], 64'h0);
            chk("str_d0", 64'(wd[0]), 64'h04030201);
            chk("str_a1", wa[1], 64'h4);
            chk("str_d1", 64'(wd[1]), 64'h08070605);
            chk("str_a2", wa[2], 64'h8);
            chk("str_d2", 64'(wd[2]), 64'h0C0B0A09);
        end
        chk("str_done", 64'(DONE), 64'd1);

        // Reset in the middle of a word
        clr_log();
        start_pulse();
        send(8'h01); send(8'h00);
        send(8'h55); send(8'h66);
        BYTE_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("mrst_busy", 64'(BUSY), 64'd0);
        chk("mrst_core", 64'(CORE_RST), 64'd1);
        chk("mrst_cnt", 64'(WORDS_WRITTEN), 64'd0);
        chk("mrst_rdy", 64'(BYTE_READY), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        start_pulse();
        send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        BYTE_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        chk("mrst_nwr", 64'(wa.size()), 64'd1);
        if (wa.size() == 1) begin
            chk("mrst_a0", wa[0], 64'h0);
            chk("mrst_d0", 64'(wd[0]), 64'hDDCCBBAA);
        end
        chk("mrst_done", 64'(DONE), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 64'd0, first instruction-memory write address.
REQ-002 Parameter MAX_WORDS, default 16'd1024, largest accepted program length in words.
REQ-003 Parameter TIMEOUT, default 16'd1000, idle cycles tolerated between bytes mid-load.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 START  input  1  one-cycle request to begin a program load.
REQ-007 BYTE_IN  input  8  incoming program byte.
REQ-008 BYTE_VALID  input  1  BYTE_IN valid.
REQ-009 BYTE_READY  output  1  loader accepts a byte this cycle.
REQ-010 WADDRESS  output  64  instruction-memory write address.
REQ-011 DATAIN  output  32  instruction-memory write data.
REQ-012 WR  output  1  instruction-memory write strobe, one cycle per word.
REQ-013 CORE_RST  output  1  active-high hold of processor state machine/PC in reset.
REQ-014 BUSY, DONE, ERR  output  1 each  loader status.
REQ-015 WORDS_WRITTEN  output  16  count of words written in the current load.

Function
REQ-016 Byte transfer SHALL occur only on a rising edge with BYTE_VALID and BYTE_READY both high.
REQ-017 States SHALL be IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR + START -> LEN0, clearing WORDS_WRITTEN, byte index and ERR/DONE; START ignored in all other states.
REQ-019 LEN0 accepts low length byte -> LEN1; LEN1 accepts high length byte forming 16-bit N.
REQ-020 From LEN1: N==0 -> DONE; N>MAX_WORDS -> ERROR; else -> DATA.
REQ-021 DATA packs 4 bytes little-endian (first byte = DATAIN[7:0]); 4th accepted byte -> WRITE.
REQ-022 WRITE lasts exactly one cycle: WR=1, WADDRESS=BASE_ADDR+4*WORDS_WRITTEN, DATAIN=packed word; BYTE_READY=0.
REQ-023 Leaving WRITE, WORDS_WRITTEN increments; equal to N -> DONE, else -> DATA.
REQ-024 WADDRESS addition SHALL be 64-bit modulo 2^64 (wrap allowed, no error).
REQ-025 BYTE_READY=1 only in LEN0, LEN1, DATA.
REQ-026 Timeout counter clears on every accepted byte and on entering LEN1/DATA; in LEN1 or DATA, reaching TIMEOUT -> ERROR; LEN0 waits indefinitely.
REQ-027 WR, DATAIN, WADDRESS SHALL hold 0 outside WRITE.
REQ-028 CORE_RST=1 in all states except DONE; DONE holds CORE_RST=0 until next START or reset.
REQ-029 BUSY=1 in LEN0..WRITE; DONE=1 only in DONE; ERR=1 only in ERROR.
REQ-030 A BYTE_VALID during WRITE SHALL be left pending (not lost) and accepted the next cycle.

Reset
REQ-031 RST low SHALL immediately force IDLE, CORE_RST=1, BYTE_READY=0, WR=0, WADDRESS=0, DATAIN=0, BUSY=0, DONE=0, ERR=0, WORDS_WRITTEN=0, timeout=0.
REQ-032 Reset mid-load SHALL abandon the partial word with no write; memory already written is untouched.

Structure
REQ-033 Package loader_pkg SHALL hold the state enum and default constants for BASE_ADDR, MAX_WORDS, TIMEOUT.
REQ-034 Sub-module byte_packer SHALL hold the 32-bit little-endian shift register and 2-bit byte index.

Verification
REQ-035 START, bytes 02 00 13 00 00 00 93 00 10 00 -> WR at 0x0 data 0x00000013, then at 0x4 data 0x00100093; DONE=1, CORE_RST=0, WORDS_WRITTEN=2.
REQ-036 START, length 00 00 -> DONE next cycle, no WR pulse, CORE_RST=0.
REQ-037 START, length 01 04 (1025) -> ERROR, ERR=1, CORE_RST=1, no WR.
REQ-038 TIMEOUT=16, one word sent then BYTE_VALID held low 16 cycles in DATA -> ERROR, WORDS_WRITTEN=1.
REQ-039 BYTE_VALID held high continuously through a 3-word load -> BYTE_READY low only in the WRITE cycles; all 12 data bytes written correctly in order.
REQ-040 RST low after 2 data bytes, release, fresh 1-word load -> single WR at BASE_ADDR with the new word only.
